div5_seq_ctrl: RTL and testbench
================================

DIV5_SEQ_CTRL -- requirements
Module: div5_seq_ctrl

Interface
REQ-001 Parameter BIT_WIDTH, default 32, operand width; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant NIBBLES = BIT_WIDTH/4; CW = $clog2(NIBBLES+1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_val  input  1  upstream operand valid.
REQ-006 in_rdy  output  1  controller accepts operand; transfer when in_val & in_rdy.
REQ-007 all_z  input  1  datapath remaining-nibble register is all zero.
REQ-008 carry  input  1  datapath carry register value.
REQ-009 in_sel  output  1  1 = datapath loads operand; 0 = hold/shift.
REQ-010 acc_sel  output  1  1 = accumulate nibble; 0 = clear accumulator.
REQ-011 c_sel  output  1  1 = feed carry back as carry-in; 0 = carry-in forced 0.
REQ-012 shift_en  output  1  datapath shifts one nibble right this cycle.
REQ-013 fold_en  output  1  datapath adds stored carry into accumulator (end-around fold).
REQ-014 out_val  output  1  datapath result (divisible) is valid.
REQ-015 out_rdy  input  1  downstream accepts result.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 nib_cnt  output  CW  nibbles consumed for current operand.

Function
REQ-018 FSM states: IDLE, ACCUM, FOLD, DONE; all outputs Moore-decoded from state and registers, except in_sel, which is combinational in_val & in_rdy.
REQ-019 IDLE: in_rdy = ready_q; on handshake assert in_sel=1, acc_sel=0, c_sel=0; clear nib_cnt; next state ACCUM.
REQ-020 ACCUM: shift_en=1, acc_sel=1, c_sel=1; nib_cnt increments by 1 per cycle.
REQ-021 ACCUM -> FOLD when all_z=1 (early exit, sampled before shift) or when nib_cnt == NIBBLES-1; otherwise remain.
REQ-022 FOLD: fold_en=1, acc_sel=1, c_sel=1; remain in FOLD while carry=1, else -> DONE; FOLD SHALL last at most 2 cycles (arithmetic bound).
REQ-023 If a third consecutive FOLD cycle would occur, go to DONE anyway (defensive bound).
REQ-024 DONE: out_val=1, held stable until out_val & out_rdy; then -> IDLE.
REQ-025 in_rdy=0 in ACCUM, FOLD, DONE; in_val ignored there; no operand accepted in the same cycle a result is taken.
REQ-026 Latency, no early exit, carry=0: handshake edge T0, ACCUM T1..T(NIBBLES), FOLD T(NIBBLES+1), out_val first high in cycle T(NIBBLES+2).
REQ-027 nib_cnt saturates at NIBBLES; never wraps.
REQ-028 Simultaneous all_z=1 and nib_cnt==NIBBLES-1: single transition to FOLD.

Reset
REQ-029 While rst=0: state=IDLE, nib_cnt=0, fold counter=0, ready_q=0; in_rdy, in_sel, shift_en, fold_en, out_val, busy all 0.
REQ-030 ready_q SHALL set on the first rising edge after rst deasserts; in_rdy therefore first high in the second cycle after release.
REQ-031 Reset asserted mid-operation SHALL abort immediately; the in-flight operand is discarded and no out_val is produced.

Structure
REQ-032 Shared package div5_pkg holds the state enum type and the NIBBLES/CW derivation functions.
REQ-033 One sub-module, div5_nib_counter (saturating counter with clear/enable), SHALL implement nib_cnt.
REQ-034 A parameter check SHALL flag BIT_WIDTH not a multiple of 4 at elaboration.

Verification
REQ-035 Reset: hold rst=0 for 3 cycles with in_val=1 -> in_rdy=0, out_val=0; after release in_rdy=0 for cycle 1 and 1 in cycle 2.
REQ-036 Full word, BIT_WIDTH=32, all_z=0, carry=0 -> 8 ACCUM cycles, 1 FOLD cycle, out_val high at T10, nib_cnt=8.
REQ-037 Early exit: all_z=1 in the 3rd ACCUM cycle -> FOLD next cycle, nib_cnt=3, out_val at T5.
REQ-038 Carry fold: carry=1 in the first FOLD cycle, 0 in the second -> exactly 2 FOLD cycles, out_val delayed by 1 cycle versus REQ-036.
REQ-039 Backpressure: out_rdy=0 for 5 cycles while in_val=1 -> out_val held high, in_rdy=0, no in_sel pulse; out_rdy=1 -> IDLE next cycle.
REQ-040 Mid-op reset: rst=0 in the 4th ACCUM cycle -> all outputs 0 immediately, no out_val afterward, new operand accepted normally.

Source files
------------

// File: rtl/div5_pkg.sv
// Shared types and width derivations for the divide-by-5 sequencing controller.
package div5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Two fold cycles always suffice arithmetically; the limit is a safety net.
  localparam logic [1:0] FOLD_MAX = 2'd2;

  function automatic int nibbles_f(input int bit_width);
    return bit_width / 4;
  endfunction

  function automatic int cw_f(input int bit_width);
    return $clog2((bit_width / 4) + 1);
  endfunction

endpackage

// File: rtl/div5_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the controller and its neighbours.
interface div5_seq_ctrl_if
  import div5_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) ();

  localparam int CW = cw_f(BIT_WIDTH);

  logic          in_val;
  logic          in_rdy;
  logic          all_z;
  logic          carry;
  logic          in_sel;
  logic          acc_sel;
  logic          c_sel;
  logic          shift_en;
  logic          fold_en;
  logic          out_val;
  logic          out_rdy;
  logic          busy;
  logic [CW-1:0] nib_cnt;

  modport master (
    output in_val, all_z, carry, out_rdy,
    input  in_rdy, in_sel, acc_sel, c_sel, shift_en, fold_en, out_val, busy, nib_cnt
  );

  modport slave (
    input  in_val, all_z, carry, out_rdy,
    output in_rdy, in_sel, acc_sel, c_sel, shift_en, fold_en, out_val, busy, nib_cnt
  );

endinterface

// File: rtl/div5_nib_counter.sv
// Saturating nibble counter with synchronous clear (clear wins over enable).
module div5_nib_counter #(
  parameter int MAX = 8,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_r;

  // Count register: never wraps past MAX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && (cnt_r < CW'(MAX))) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/div5_seq_ctrl.sv
// Sequencing controller for a nibble-serial divisible-by-5 datapath:
// accepts an operand, walks its nibbles, folds the end-around carry, presents the result.
module div5_seq_ctrl
  import div5_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  div5_seq_ctrl_if.slave bus
);

  localparam int NIBBLES = nibbles_f(BIT_WIDTH);
  localparam int CW      = cw_f(BIT_WIDTH);

  if (((BIT_WIDTH % 4) != 0) || (BIT_WIDTH < 8)) begin : g_bad_width
    $error("div5_seq_ctrl: BIT_WIDTH must be a multiple of 4 and at least 8");
  end

  state_e        state_r;
  state_e        state_s;
  logic [1:0]    fold_cnt_r;
  logic [1:0]    fold_cnt_s;
  logic [CW-1:0] cnt_s;
  logic          hs_s;
  logic          last_nib_s;

  logic in_rdy_r;
  logic acc_sel_r;
  logic c_sel_r;
  logic shift_en_r;
  logic fold_en_r;
  logic out_val_r;
  logic busy_r;

  assign hs_s       = bus.in_val & in_rdy_r;
  assign last_nib_s = (cnt_s == CW'(NIBBLES - 1));

  div5_nib_counter #(
    .MAX (NIBBLES),
    .CW  (CW)
  ) u_nib_counter (
    .clk (clk),
    .rst (rst),
    .clr (hs_s),
    .en  (state_r == ST_ACCUM),
    .cnt (cnt_s)
  );

  // State and fold-count registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      fold_cnt_r <= 2'd0;
    end else begin
      state_r    <= state_s;
      fold_cnt_r <= fold_cnt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s    = state_r;
    fold_cnt_s = fold_cnt_r;
    case (state_r)
      ST_IDLE: begin
        fold_cnt_s = 2'd0;
        if (hs_s) state_s = ST_ACCUM;
        else      state_s = ST_IDLE;
      end
      ST_ACCUM: begin
        if (bus.all_z || last_nib_s) state_s = ST_FOLD;
        else                         state_s = ST_ACCUM;
      end
      ST_FOLD: begin
        // A carry may extend the fold once; a third cycle is cut off
        if (bus.carry && (fold_cnt_r < (FOLD_MAX - 2'd1))) begin
          state_s    = ST_FOLD;
          fold_cnt_s = fold_cnt_r + 2'd1;
        end else begin
          state_s    = ST_DONE;
          fold_cnt_s = 2'd0;
        end
      end
      ST_DONE: begin
        if (bus.out_rdy) state_s = ST_IDLE;
        else             state_s = ST_DONE;
      end
      default: begin
        state_s    = ST_IDLE;
        fold_cnt_s = 2'd0;
      end
    endcase
  end

  // Output registers decoded from the upcoming state, so each tracks state_r exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_rdy_r   <= 1'b0;
      acc_sel_r  <= 1'b0;
      c_sel_r    <= 1'b0;
      shift_en_r <= 1'b0;
      fold_en_r  <= 1'b0;
      out_val_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      in_rdy_r   <= (state_s == ST_IDLE);
      acc_sel_r  <= (state_s == ST_ACCUM) || (state_s == ST_FOLD);
      c_sel_r    <= (state_s == ST_ACCUM) || (state_s == ST_FOLD);
      shift_en_r <= (state_s == ST_ACCUM);
      fold_en_r  <= (state_s == ST_FOLD);
      out_val_r  <= (state_s == ST_DONE);
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  assign bus.in_rdy   = in_rdy_r;
  assign bus.in_sel   = hs_s;
  assign bus.acc_sel  = acc_sel_r;
  assign bus.c_sel    = c_sel_r;
  assign bus.shift_en = shift_en_r;
  assign bus.fold_en  = fold_en_r;
  assign bus.out_val  = out_val_r;
  assign bus.busy     = busy_r;
  assign bus.nib_cnt  = cnt_s;

endmodule

// File: tb/tb_div5_seq_ctrl.sv
// Randomized self-checking bench for div5_seq_ctrl; expectations come from a
// per-operation timeline (ACCUM length, FOLD length, DONE hold) derived arithmetically.
module tb_div5_seq_ctrl;

  localparam int BW  = 32;
  localparam int NIB = BW / 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  div5_seq_ctrl_if #(.BIT_WIDTH(BW)) bus ();

  div5_seq_ctrl #(.BIT_WIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One operation: k = ACCUM cycle where all_z first rises (>NIB means never),
  // c1/c2 = carry in first/second FOLD cycle, bp = extra cycles out_rdy stays low.
  task automatic run_op(input int k, input bit c1, input bit c2, input int bp);
    int acc;
    int fold;
    int d;
    int last;
    acc  = (k < NIB) ? k : NIB;
    fold = c1 ? 2 : 1;
    d    = acc + fold + 1;
    last = d + bp + 1;

    @(negedge clk);
    bus.in_val  = 1'b1;
    bus.all_z   = 1'($urandom_range(0, 1));
    bus.carry   = 1'($urandom_range(0, 1));
    bus.out_rdy = 1'($urandom_range(0, 1));
    #1;
    check("idle_in_rdy",  bus.in_rdy,  1);
    check("idle_in_sel",  bus.in_sel,  1);
    check("idle_out_val", bus.out_val, 0);
    check("idle_busy",    bus.busy,    0);

    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      bus.in_val  = (t == last) ? 1'b0 : ((t >= d) ? 1'b1 : 1'($urandom_range(0, 1)));
      bus.all_z   = (t <= acc) ? (t >= k) : 1'($urandom_range(0, 1));
      bus.carry   = (t == acc + 1) ? c1 : ((t == acc + 2) ? c2 : 1'($urandom_range(0, 1)));
      bus.out_rdy = (t >= d + bp);
      #1;
      if (t < last) begin
        check("busy",     bus.busy,     1);
        check("in_rdy",   bus.in_rdy,   0);
        check("in_sel",   bus.in_sel,   0);
        check("shift_en", bus.shift_en, int'(t <= acc));
        check("fold_en",  bus.fold_en,  int'((t > acc) && (t <= acc + fold)));
        check("acc_sel",  bus.acc_sel,  int'(t <= acc + fold));
        check("c_sel",    bus.c_sel,    int'(t <= acc + fold));
        check("out_val",  bus.out_val,  int'(t >= d));
        check("nib_cnt",  bus.nib_cnt,  (t <= acc) ? (t - 1) : acc);
      end else begin
        check("back_idle_busy",    bus.busy,    0);
        check("back_idle_out_val", bus.out_val, 0);
        check("back_idle_in_rdy",  bus.in_rdy,  1);
      end
    end
  endtask

  // Reset lands in the 4th ACCUM cycle; everything must drop at once.
  task automatic mid_op_reset();
    @(negedge clk);
    bus.in_val = 1'b1;
    bus.all_z  = 1'b0;
    #1;
    check("mr_hs_in_sel", bus.in_sel, 1);
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      bus.in_val = 1'($urandom_range(0, 1));
      bus.all_z  = 1'b0;
      #1;
      check("mr_shift_en", bus.shift_en, 1);
      check("mr_nib_cnt",  bus.nib_cnt,  t - 1);
    end
    @(negedge clk);
    rst        = 1'b0;
    bus.in_val = 1'b1;
    #1;
    check("mr_in_rdy",   bus.in_rdy,   0);
    check("mr_in_sel",   bus.in_sel,   0);
    check("mr_shift_en", bus.shift_en, 0);
    check("mr_fold_en",  bus.fold_en,  0);
    check("mr_out_val",  bus.out_val,  0);
    check("mr_busy",     bus.busy,     0);
    check("mr_nib_zero", bus.nib_cnt,  0);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("mr_hold_out_val", bus.out_val, 0);
      check("mr_hold_busy",    bus.busy,    0);
    end
    @(negedge clk);
    rst        = 1'b1;
    bus.in_val = 1'b0;
    #1;
    check("mr_rel_in_rdy", bus.in_rdy, 0);
  endtask

  initial begin
    bus.in_val  = 1'b1;
    bus.all_z   = 1'b0;
    bus.carry   = 1'b0;
    bus.out_rdy = 1'b0;
    rst         = 1'b0;

    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_in_rdy",  bus.in_rdy,  0);
      check("rst_in_sel",  bus.in_sel,  0);
      check("rst_out_val", bus.out_val, 0);
      check("rst_busy",    bus.busy,    0);
    end
    @(negedge clk);
    rst        = 1'b1;
    bus.in_val = 1'b0;
    #1;
    check("rel_cycle1_in_rdy", bus.in_rdy, 0);
    @(negedge clk);
    #1;
    check("rel_cycle2_in_rdy", bus.in_rdy, 1);

    run_op(99, 1'b0, 1'b0, 0);  // full word, out_val at T10
    run_op(3,  1'b0, 1'b0, 0);  // early exit, out_val at T5
    run_op(99, 1'b1, 1'b0, 0);  // two fold cycles
    run_op(99, 1'b1, 1'b1, 0);  // fold capped at two
    run_op(NIB, 1'b0, 1'b0, 0); // all_z together with last nibble
    run_op(1,  1'b0, 1'b0, 0);  // shortest operand
    run_op(99, 1'b0, 1'b0, 5);  // backpressure
    mid_op_reset();
    run_op(99, 1'b0, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      run_op(int'($urandom_range(1, NIB + 2)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
